// File: rtl/branch_prediction_table.sv
// Fetch-side bimodal/gshare predictor: saturating counter table with
// speculative global history, repair on mispredict, and saturating stats.
module branch_prediction_table #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 0,
  parameter int STAT_W = 16,
  localparam int HW    = (HIST_W > 0) ? HIST_W : 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              prediction,
  output logic              pred_valid,
  output logic [HW-1:0]     pred_hist,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [HW-1:0]     upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_RST =
    CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic [HW-1:0]     ghr_q, ghr_d;
  logic [HW-1:0]     hist_q, hist_d;
  logic              pred_q, pred_d;
  logic              pv_q, pv_d;
  logic [STAT_W-1:0] lk_q, lk_d;
  logic [STAT_W-1:0] mp_q, mp_d;

  logic [ADDR_W-1:0] ghr_ext, uh_ext;
  logic [ADDR_W-1:0] rd_idx, upd_idx;
  logic [CNT_W-1:0]  upd_old, upd_new, rd_cnt;
  logic              rd_en, upd_en, rep_en;

  assign rd_en  = en & rd_valid;
  assign upd_en = en & upd_valid;
  assign rep_en = upd_en & upd_mispredict;

  always_comb begin
    ghr_ext = '0;
    uh_ext  = '0;
    if (HIST_W > 0) begin
      ghr_ext[HW-1:0] = ghr_q;
      uh_ext[HW-1:0]  = upd_hist;
    end
    rd_idx  = rd_addr ^ ghr_ext;
    upd_idx = upd_addr ^ uh_ext;
  end

  always_comb begin
    upd_old = cnt_q[upd_idx];
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != CNT_MAX) upd_new = upd_old + CNT_ONE;
    end else begin
      if (upd_old != CNT_MIN) upd_new = upd_old - CNT_ONE;
    end
  end

  // Write-first: a same-index update is seen by this cycle's lookup
  always_comb begin
    rd_cnt = cnt_q[rd_idx];
    if (upd_en && (upd_idx == rd_idx)) rd_cnt = upd_new;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) cnt_d[i] = cnt_q[i];
    if (upd_en) cnt_d[upd_idx] = upd_new;
  end

  // Repair beats the speculative shift when both happen together
  always_comb begin
    ghr_d = ghr_q;
    if (rep_en)
      ghr_d = (upd_hist << 1) | HW'(upd_taken);
    else if (rd_en)
      ghr_d = (ghr_q << 1) | HW'(rd_cnt[CNT_W-1]);
    if (HIST_W == 0) ghr_d = '0;
  end

  always_comb begin
    pred_d = pred_q;
    hist_d = hist_q;
    pv_d   = 1'b0;
    if (rd_en) begin
      pred_d = rd_cnt[CNT_W-1];
      hist_d = ghr_q;
      pv_d   = 1'b1;
    end
  end

  always_comb begin
    lk_d = lk_q;
    mp_d = mp_q;
    if (rd_en && (lk_q != STAT_MAX)) lk_d = lk_q + STAT_ONE;
    if (rep_en && (mp_q != STAT_MAX)) mp_d = mp_q + STAT_ONE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
      ghr_q  <= '0;
      hist_q <= '0;
      pred_q <= 1'b0;
      pv_q   <= 1'b0;
      lk_q   <= '0;
      mp_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
      ghr_q  <= ghr_d;
      hist_q <= hist_d;
      pred_q <= pred_d;
      pv_q   <= pv_d;
      lk_q   <= lk_d;
      mp_q   <= mp_d;
    end
  end

  assign prediction       = pred_q;
  assign pred_valid       = pv_q;
  assign pred_hist        = hist_q;
  assign stat_lookups     = lk_q;
  assign stat_mispredicts = mp_q;

endmodule
